dmem_mmio_bus: RTL and testbench
================================

Name: dmem_mmio_bus

Overview:
- Slave on the single-cycle core's data-memory port: address, write enable, write data in; read data out.
- Decodes byte addresses into a word-wide data RAM and a small memory-mapped I/O region.
- MMIO region holds an LED register, a 32-bit timer with compare/interrupt flag, and an 8N1 UART transmitter.
- Reads are combinational, because the core completes loads in the same cycle. All writes take effect on the clock edge.

Parameters:
- XLen, 32, data word width
- AddrWidth, 16, byte-address width of the core data port
- DmemWords, 1024, RAM depth in 32-bit words (power of two)
- LedWidth, 8, width of LED output register
- ClkPerBit, 434, clock cycles per UART bit (50 MHz / 115200)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- addr_i  in  AddrWidth  byte address from core
- we_i  in  1  store enable from core
- wdata_i  in  XLen  store data
- rdata_o  out  XLen  load data, combinational
- led_o  out  LedWidth  LED register
- uart_tx_o  out  1  serial output, idles high
- timer_irq_o  out  1  sticky timer match flag

Behaviour:
- Addressing: addr_i[1:0] ignored; accesses are full words only.
- Address map:
  - addr_i[AddrWidth-1]=0: RAM, word index addr_i[log2(DmemWords)+1:2]. Higher address bits alias.
  - addr_i[AddrWidth-1]=1: MMIO, decoded on addr_i[4:2] with the remaining bits ignored. Offsets:
    - 0x00 LED (RW)
    - 0x04 TCOUNT (RW)
    - 0x08 TCMP (RW)
    - 0x0C TSTAT (bit0 match flag; write bit0=1 clears)
    - 0x10 UTXDATA (W; reads 0)
    - 0x14 USTAT (bit0 busy, R)
- Unmapped MMIO offsets: read 0, writes ignored.
- Register field widths: LED read returns {zero-pad, led}; upper wdata bits dropped on write.
- RAM: async read, sync write on posedge when we_i and RAM selected. Contents are not reset; power-up values are undefined.
- Read-during-write: rdata_o shows the old value in the write cycle and the new value from the next cycle.
- Reset values: led_o=0, uart_tx_o=1, timer_irq_o=0, TCOUNT=0, TCMP=0xFFFF_FFFF, UART state IDLE, busy=0.
- Timer:
  - TCOUNT increments by 1 every cycle and wraps 0xFFFF_FFFF->0.
  - A write to TCOUNT loads wdata_i; the write wins over the increment.
  - When the current TCOUNT equals TCMP, the flag sets on the next edge and stays set until cleared. timer_irq_o = flag.
  - Clear and set in the same cycle: set wins.
- UART:
  - Writing UTXDATA while not busy latches wdata_i[7:0] and enters START on the next edge. busy=1 from that edge.
  - Writing UTXDATA while busy is ignored and the data is dropped.
  - FSM: IDLE -> START (tx=0) -> DATA (8 bits, LSB first) -> STOP (tx=1) -> IDLE.
  - Each bit lasts exactly ClkPerBit cycles, counted by a bit timer of width $clog2(ClkPerBit). A 3-bit index selects the data bit.
  - busy clears on the edge that ends STOP. A new write in that same cycle is accepted because busy is sampled before the edge.
  - Frame length is 10*ClkPerBit cycles from the first cycle of START.
- Reset mid-operation: asynchronous. All registers return to their reset values immediately and uart_tx_o returns high; a partial frame is abandoned.
- There is no back-pressure to the core. Every access completes in one cycle.

Decomposition:
- Package dmem_mmio_pkg holds:
  - MMIO offset localparams: LED, TCOUNT, TCMP, TSTAT, UTXDATA, USTAT
  - typedef enum logic [1:0] uart_state_e {IDLE, START, DATA, STOP}
- Sub-module uart_tx:
  - Parameter ClkPerBit.
  - Ports: clk_i, rst_ni, start_i, data_i[7:0], busy_o, tx_o.
- The top level keeps the address decode, RAM, LED and timer.

Test Plan:
- Store 0xDEADBEEF to 0x0010, then load 0x0010 and 0x1010 (alias when DmemWords=1024) -> both return 0xDEADBEEF. Load 0x0013 -> same word.
- Reset, then read LED/TCMP/TSTAT/USTAT:
  - returns 0 / 0xFFFF_FFFF / 0 / 0; uart_tx_o=1.
  - Write 0x1A5 to LED -> led_o=0xA5; LED readback 0x000000A5.
- Timer match:
  - TCMP=20, TCOUNT=10 -> timer_irq_o rises exactly 11 edges after the TCOUNT write.
  - Writing 1 to TSTAT clears it.
  - Clear coinciding with a match leaves it set.
- Timer wrap: TCOUNT=0xFFFF_FFFE -> reads 0xFFFF_FFFF, then 0x0000_0000 on successive cycles.
- UART with ClkPerBit=4: write 0x55 to UTXDATA:
  - tx waveform: 0, then 1,0,1,0,1,0,1,0, then 1; each level held 4 cycles.
  - busy=1 for 40 cycles.
  - A second write of 0xFF during busy produces no frame.
  - Back-to-back write on the final STOP cycle starts the next frame with no idle gap.
- Assert rst_ni low mid-DATA -> uart_tx_o=1 and busy=0 immediately. After release, an UTXDATA write sends a full fresh frame.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO slave: register offsets
// within the MMIO window and the UART transmitter state encoding.
package dmem_mmio_pkg;

   // Byte offsets of the MMIO registers (decoded on address bits [4:2])
   localparam logic [4:0] LED_OFS     = 5'h00;
   localparam logic [4:0] TCOUNT_OFS  = 5'h04;
   localparam logic [4:0] TCMP_OFS    = 5'h08;
   localparam logic [4:0] TSTAT_OFS   = 5'h0C;
   localparam logic [4:0] UTXDATA_OFS = 5'h10;
   localparam logic [4:0] USTAT_OFS   = 5'h14;

   // Word indices derived from the byte offsets
   localparam logic [2:0] LED_IDX     = LED_OFS[4:2];
   localparam logic [2:0] TCOUNT_IDX  = TCOUNT_OFS[4:2];
   localparam logic [2:0] TCMP_IDX    = TCMP_OFS[4:2];
   localparam logic [2:0] TSTAT_IDX   = TSTAT_OFS[4:2];
   localparam logic [2:0] UTXDATA_IDX = UTXDATA_OFS[4:2];
   localparam logic [2:0] USTAT_IDX   = USTAT_OFS[4:2];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/dmem_mmio_bus_uart_tx.sv
// 8N1 serial transmitter. A start request is honoured in IDLE, or in the
// last cycle of STOP so that back-to-back frames leave no idle gap.
// tx_o and busy_o come straight from flops.
module uart_tx
   import dmem_mmio_pkg::*;
#(
   parameter int ClkPerBit = 434
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       busy_o,
   output logic       tx_o
);

   localparam int CntW = (ClkPerBit > 1) ? $clog2(ClkPerBit) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ClkPerBit - 1);

   uart_state_e     state_r, state_s;
   logic [CntW-1:0] cnt_r, cnt_s;
   logic [2:0]      idx_r, idx_s;
   logic [7:0]      data_r, data_s;
   logic            tx_r, tx_s;
   logic            busy_r, busy_s;
   logic            bit_done_s;

   assign bit_done_s = (cnt_r == CntLast);

   // Next-state, bit timer, bit index and next line level
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + CntW'(1);
      idx_s   = idx_r;
      data_s  = data_r;
      tx_s    = tx_r;
      case (state_r)
         IDLE: begin
            cnt_s = '0;
            if (start_i) begin
               state_s = START;
               data_s  = data_i;
               idx_s   = 3'd0;
               tx_s    = 1'b0;
            end else begin
               state_s = IDLE;
               tx_s    = 1'b1;
            end
         end
         START: begin
            if (bit_done_s) begin
               state_s = DATA;
               cnt_s   = '0;
               idx_s   = 3'd0;
               tx_s    = data_r[0];
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (bit_done_s) begin
               cnt_s = '0;
               if (idx_r == 3'd7) begin
                  state_s = STOP;
                  tx_s    = 1'b1;
               end else begin
                  state_s = DATA;
                  idx_s   = idx_r + 3'd1;
                  tx_s    = data_r[idx_s];
               end
            end else begin
               state_s = DATA;
            end
         end
         STOP: begin
            if (bit_done_s) begin
               cnt_s = '0;
               if (start_i) begin
                  state_s = START;
                  data_s  = data_i;
                  idx_s   = 3'd0;
                  tx_s    = 1'b0;
               end else begin
                  state_s = IDLE;
                  tx_s    = 1'b1;
               end
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
            tx_s    = 1'b1;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and datapath registers; reset abandons any frame and idles the line
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         idx_r   <= 3'd0;
         data_r  <= 8'h00;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         data_r  <= data_s;
         tx_r    <= tx_s;
         busy_r  <= busy_s;
      end
   end

   assign tx_o   = tx_r;
   assign busy_o = busy_r;

endmodule

// File: rtl/dmem_mmio_bus.sv
// Data-memory port slave: word RAM in the lower half of the address space,
// LED / timer / UART registers in the upper half. Loads are combinational
// so the core can complete them in the same cycle; stores land on the edge.
module dmem_mmio_bus
   import dmem_mmio_pkg::*;
#(
   parameter int XLen      = 32,
   parameter int AddrWidth = 16,
   parameter int DmemWords = 1024,
   parameter int LedWidth  = 8,
   parameter int ClkPerBit = 434
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic                 we_i,
   input  logic [XLen-1:0]      wdata_i,
   output logic [XLen-1:0]      rdata_o,
   output logic [LedWidth-1:0]  led_o,
   output logic                 uart_tx_o,
   output logic                 timer_irq_o
);

   localparam int IdxW = $clog2(DmemWords);

   logic [XLen-1:0]     mem_r [DmemWords];
   logic [LedWidth-1:0] led_r;
   logic [XLen-1:0]     tcount_r;
   logic [XLen-1:0]     tcmp_r;
   logic                irq_r;

   logic                ram_sel_s;
   logic [IdxW-1:0]     word_idx_s;
   logic [2:0]          mmio_idx_s;
   logic                led_we_s, tcount_we_s, tcmp_we_s, tstat_we_s, utx_we_s;
   logic                match_s;
   logic                uart_busy_s;
   logic [XLen-1:0]     rdata_s;
   logic                unused_addr_s;

   assign ram_sel_s   = ~addr_i[AddrWidth-1];
   assign word_idx_s  = addr_i[IdxW+1:2];
   assign mmio_idx_s  = addr_i[4:2];
   assign match_s     = (tcount_r == tcmp_r);
   // Byte lane bits and RAM alias bits carry no information here
   assign unused_addr_s = ^{addr_i[AddrWidth-2:IdxW+2], addr_i[1:0]};

   // MMIO write strobes; nothing fires for RAM or unmapped offsets
   always_comb begin
      led_we_s    = 1'b0;
      tcount_we_s = 1'b0;
      tcmp_we_s   = 1'b0;
      tstat_we_s  = 1'b0;
      utx_we_s    = 1'b0;
      if (we_i && !ram_sel_s) begin
         case (mmio_idx_s)
            LED_IDX:     led_we_s    = 1'b1;
            TCOUNT_IDX:  tcount_we_s = 1'b1;
            TCMP_IDX:    tcmp_we_s   = 1'b1;
            TSTAT_IDX:   tstat_we_s  = 1'b1;
            UTXDATA_IDX: utx_we_s    = 1'b1;
            default:     led_we_s    = 1'b0;
         endcase
      end else begin
         led_we_s = 1'b0;
      end
   end

   // Combinational load path: RAM word or zero-extended MMIO register
   always_comb begin
      rdata_s = '0;
      if (ram_sel_s) begin
         rdata_s = mem_r[word_idx_s];
      end else begin
         case (mmio_idx_s)
            LED_IDX:     rdata_s = {{(XLen-LedWidth){1'b0}}, led_r};
            TCOUNT_IDX:  rdata_s = tcount_r;
            TCMP_IDX:    rdata_s = tcmp_r;
            TSTAT_IDX:   rdata_s = {{(XLen-1){1'b0}}, irq_r};
            USTAT_IDX:   rdata_s = {{(XLen-1){1'b0}}, uart_busy_s};
            default:     rdata_s = '0;
         endcase
      end
   end

   // RAM store port; contents are deliberately not reset
   always_ff @(posedge clk_i) begin
      if (we_i && ram_sel_s) begin
         mem_r[word_idx_s] <= wdata_i;
      end
   end

   // LED register and free-running timer with sticky compare flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         led_r    <= '0;
         tcount_r <= '0;
         tcmp_r   <= '1;
         irq_r    <= 1'b0;
      end else begin
         if (led_we_s) begin
            led_r <= wdata_i[LedWidth-1:0];
         end
         if (tcount_we_s) begin
            tcount_r <= wdata_i;
         end else begin
            tcount_r <= tcount_r + XLen'(1);
         end
         if (tcmp_we_s) begin
            tcmp_r <= wdata_i;
         end
         // A match in the same cycle as a clear keeps the flag set
         if (match_s) begin
            irq_r <= 1'b1;
         end else if (tstat_we_s && wdata_i[0]) begin
            irq_r <= 1'b0;
         end
      end
   end

   uart_tx #(
      .ClkPerBit(ClkPerBit)
   ) u_uart_tx (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .start_i(utx_we_s),
      .data_i (wdata_i[7:0]),
      .busy_o (uart_busy_s),
      .tx_o   (uart_tx_o)
   );

   assign rdata_o     = rdata_s;
   assign led_o       = led_r;
   assign timer_irq_o = irq_r;

endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Directed bench for dmem_mmio_bus with a short UART bit period.
module tb_dmem_mmio_bus;

   localparam logic [15:0] A_LED    = 16'h8000;
   localparam logic [15:0] A_TCOUNT = 16'h8004;
   localparam logic [15:0] A_TCMP   = 16'h8008;
   localparam logic [15:0] A_TSTAT  = 16'h800C;
   localparam logic [15:0] A_UTX    = 16'h8010;
   localparam logic [15:0] A_USTAT  = 16'h8014;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  led;
   logic        uart_tx;
   logic        irq;

   int checks = 0;
   int errors = 0;

   dmem_mmio_bus #(
      .XLen(32), .AddrWidth(16), .DmemWords(1024), .LedWidth(8), .ClkPerBit(4)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .addr_i     (addr),
      .we_i       (we),
      .wdata_i    (wdata),
      .rdata_o    (rdata),
      .led_o      (led),
      .uart_tx_o  (uart_tx),
      .timer_irq_o(irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [31:0] d);
      addr = a; we = 1'b0;
      #1;
      d = rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", uart_tx); end
      checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led_o got %h exp 00", led); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rd(A_LED, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_led_rd got %h exp 00000000", d); end
      rd(A_TCMP, d);
      checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_tcmp got %h exp ffffffff", d); end
      rd(A_TSTAT, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_tstat got %h exp 00000000", d); end
      rd(A_USTAT, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ustat got %h exp 00000000", d); end
   endtask

   task automatic test_ram();
      logic [31:0] d;
      wr(16'h0010, 32'hDEAD_BEEF);
      rd(16'h0010, d);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd got %h exp deadbeef", d); end
      rd(16'h1010, d);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias got %h exp deadbeef", d); end
      rd(16'h0013, d);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_bytelane got %h exp deadbeef", d); end
      wr(16'h0024, 32'h0BAD_F00D);
      rd(16'h0010, d);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_neighbour got %h exp deadbeef", d); end
      // read-during-write: old value in the write cycle, new value after
      @(negedge clk);
      addr = 16'h0010; wdata = 32'h1234_5678; we = 1'b1;
      #1;
      checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rdw_old got %h exp deadbeef", rdata); end
      @(posedge clk); #1;
      we = 1'b0;
      rd(16'h0010, d);
      checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_rdw_new got %h exp 12345678", d); end
   endtask

   task automatic test_led_unmapped();
      logic [31:0] d;
      wr(A_LED, 32'h0000_01A5);
      checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_o got %h exp a5", led); end
      rd(A_LED, d);
      checks++; if (d !== 32'h0000_00A5) begin errors++; $display("FAIL led_rd got %h exp 000000a5", d); end
      rd(16'h8020, d);
      checks++; if (d !== 32'h0000_00A5) begin errors++; $display("FAIL led_alias got %h exp 000000a5", d); end
      wr(16'h801C, 32'hFFFF_FFFF);
      checks++; if (led !== 8'hA5) begin errors++; $display("FAIL unmapped_wr got %h exp a5", led); end
      rd(16'h801C, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h exp 00000000", d); end
      rd(A_UTX, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL utx_rd got %h exp 00000000", d); end
   endtask

   task automatic test_timer_match();
      logic [31:0] d;
      wr(A_TCOUNT, 32'd1000);
      wr(A_TCMP, 32'd20);
      wr(A_TSTAT, 32'h1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmr_pre got %b exp 0", irq); end
      wr(A_TCOUNT, 32'd10);
      rd(A_TCOUNT, d);
      checks++; if (d !== 32'd10) begin errors++; $display("FAIL tmr_load got %0d exp 10", d); end
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmr_early edge %0d got %b exp 0", k, irq); end
      end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_rise got %b exp 1", irq); end
      repeat (3) @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_sticky got %b exp 1", irq); end
   endtask

   task automatic test_timer_clear();
      logic [31:0] d;
      wr(A_TSTAT, 32'h0);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_clr0 got %b exp 1", irq); end
      wr(A_TSTAT, 32'h1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmr_clr got %b exp 0", irq); end
      rd(A_TSTAT, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL tmr_tstat got %h exp 00000000", d); end
      wr(A_TCMP, 32'd195);
      wr(A_TCOUNT, 32'd195);
      // matching cycle coincides with this clear
      wr(A_TSTAT, 32'h1);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_set_wins got %b exp 1", irq); end
   endtask

   task automatic test_timer_wrap();
      logic [31:0] d;
      wr(A_TCOUNT, 32'hFFFF_FFFE);
      rd(A_TCOUNT, d);
      checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap0 got %h exp fffffffe", d); end
      @(posedge clk); #1;
      rd(A_TCOUNT, d);
      checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap1 got %h exp ffffffff", d); end
      @(posedge clk); #1;
      rd(A_TCOUNT, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap2 got %h exp 00000000", d); end
   endtask

   // Writes d, checks 40 cycles of line level and busy; optionally injects a
   // write while busy (must be dropped) or chains d2 on the last STOP cycle.
   task automatic test_uart_frame(input logic [7:0] d, input bit drop, input bit chain,
                                  input logic [7:0] d2);
      logic [9:0] fb;
      logic       exp_tx;
      int         nfr;
      nfr = chain ? 2 : 1;
      wr(A_UTX, {24'h0, d});
      addr = A_USTAT;
      #1;
      for (int f = 0; f < nfr; f++) begin
         fb = {1'b1, ((f == 0) ? d : d2), 1'b0};
         for (int i = 0; i < 40; i++) begin
            exp_tx = fb[i / 4];
            checks++;
            if (uart_tx !== exp_tx) begin
               errors++; $display("FAIL uart_tx frame %0d cyc %0d got %b exp %b", f, i, uart_tx, exp_tx);
            end
            checks++;
            if (rdata !== 32'h1) begin
               errors++; $display("FAIL uart_busy frame %0d cyc %0d got %h exp 00000001", f, i, rdata);
            end
            if (f == 0 && drop && i == 6) begin
               addr = A_UTX; wdata = 32'h0000_00FF; we = 1'b1;
            end else if (f == 0 && chain && i == 39) begin
               addr = A_UTX; wdata = {24'h0, d2}; we = 1'b1;
            end
            @(posedge clk); #1;
            we = 1'b0; addr = A_USTAT;
            #1;
         end
      end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL uart_idle_busy got %h exp 00000000", rdata); end
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL uart_idle_tx got %b exp 1", uart_tx); end
      repeat (8) @(posedge clk); #1;
      checks++; if (uart_tx !== 1'b1 || rdata !== 32'h0) begin
         errors++; $display("FAIL uart_no_extra tx %b busy %h exp 1 00000000", uart_tx, rdata);
      end
   endtask

   task automatic test_reset_mid_frame();
      wr(A_UTX, 32'h0000_0000);
      addr = A_USTAT;
      repeat (12) @(posedge clk);
      #3;
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre got %b exp 0", uart_tx); end
      rst_n = 1'b0;
      #1;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b exp 1", uart_tx); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_busy got %h exp 00000000", rdata); end
      checks++; if (led !== 8'h00) begin errors++; $display("FAIL rstmid_led got %h exp 00", led); end
      @(negedge clk);
      rst_n = 1'b1;
      test_uart_frame(8'hC3, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      test_reset();
      test_ram();
      test_led_unmapped();
      test_timer_match();
      test_timer_clear();
      test_timer_wrap();
      test_uart_frame(8'h55, 1'b1, 1'b0, 8'h00);
      test_uart_frame(8'h55, 1'b0, 1'b1, 8'hA3);
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout exp finish before 2000000");
      $fatal(1, "timeout");
   end

endmodule
